// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hC;

  // Indexed {row, col}; entry 0 is row 0 / column 0 (key '1').
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3: cols 3..0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  function automatic logic is_decimal(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Scan-rate prescaler: one-cycle tick every SCAN_DIV clocks, restarted by clr.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrap the divider at SCAN_DIV-1.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  // Divider register.
  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce, key pulse and 4-digit entry shift.
// Optional: define KEYPAD_CLEAR_EN so key C clears the entry digits.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4
);

  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic          tick;
  logic [3:0]    sync1_q, sync2_q;
  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic [3:0]    d1_q, d2_q, d3_q, d4_q;
  logic [3:0]    d1_d, d2_d, d3_d, d4_d;
  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    low_idx;
  logic [3:0]    new_code;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk_i (clk),
    .clr_i (clr),
    .tick_o(tick)
  );

  // Two-flop row synchronizer; idles at all-released.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  // Classify the synchronized row pattern: single low row and its index.
  always_comb begin
    low     = ~sync2_q;
    one_low = 1'b0;
    low_idx = 2'd0;
    case (low)
      4'b0001: begin one_low = 1'b1; low_idx = 2'd0; end
      4'b0010: begin one_low = 1'b1; low_idx = 2'd1; end
      4'b0100: begin one_low = 1'b1; low_idx = 2'd2; end
      4'b1000: begin one_low = 1'b1; low_idx = 2'd3; end
      default: ;
    endcase
  end

  assign new_code = KEY_MAP[{row_q, col_q}];

  // Scan/debounce/held FSM with key acceptance and digit shifting.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    d4_d    = d4_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            row_d   = low_idx;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (low == (4'b0001 << row_q)) begin
            if (cnt_q == CNT_LAST) begin
              code_d  = new_code;
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
              if (is_decimal(new_code)) begin
                d4_d = d3_q;
                d3_d = d2_q;
                d2_d = d1_q;
                d1_d = new_code;
              end
`ifdef KEYPAD_CLEAR_EN
              else if (new_code == KEY_CLEAR) begin
                d1_d = '0;
                d2_d = '0;
                d3_d = '0;
                d4_d = '0;
              end
`endif
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            col_d   = col_q + 1'b1;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (low == '0) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              col_d   = col_q + 1'b1;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State, counters, key and digit registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      d4_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      d4_q    <= d4_d;
    end
  end

  // Active-low one-hot column drive.
  always_comb begin
    col = 4'b1110;
    case (col_q)
      2'd0: col = 4'b1110;
      2'd1: col = 4'b1101;
      2'd2: col = 4'b1011;
      2'd3: col = 4'b0111;
      default: col = 4'b1110;
    endcase
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign d1        = d1_q;
  assign d2        = d2_q;
  assign d3        = d3_q;
  assign d4        = d4_q;

endmodule
